sysid_checker: RTL and testbench

Avalon-MM master that sits directly downstream of the system ID slave and consumes its two words at boot. After reset, or on request, it reads word 0 (system ID) and then word 1 (build timestamp), and compares each against values fixed at generation time. It publishes pass/fail, timeout and the captured words, so that firmware or a front-panel LED can detect a hardware/software image mismatch without running a CPU.

---
 rtl/sysid_checker.sv | 144 ++++++++++++++
 tb/tb_sysid_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// Boot-time Avalon-MM master that reads the system ID and build timestamp words
// and reports whether they match the values this image was built against.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter bit          CHECK_TS       = 1'b1,
  parameter bit          AUTO_START     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic [31:0] id_q,
  output logic [31:0] ts_q,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        addr_q, addr_d;
  logic        read_q, read_d;
  logic [31:0] id_d, ts_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [15:0] cnt_q, cnt_d;
  // req_q is a one-cycle request that delays the launch by one edge after start
  // is sampled; arm_q injects that request on the first edge after reset.
  logic        req_q, req_d;
  logic        arm_q, arm_d;
  logic        ts_ok;

  assign ts_ok = (CHECK_TS == 1'b0) || (av_readdata == EXPECTED_TS);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    read_d    = read_q;
    id_d      = id_q;
    ts_d      = ts_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    arm_d     = 1'b0;
    req_d     = arm_q || (start && (state_q == IDLE || state_q == DONE));

    case (state_q)
      IDLE, DONE: begin
        if (req_q) begin
          state_d   = RD_ID;
          read_d    = 1'b1;
          addr_d    = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = 16'd0;
        end
      end
      RD_ID, RD_TS: begin
        if (av_waitrequest) begin
          if (cnt_q == TO_LAST) begin
            state_d   = DONE;
            read_d    = 1'b0;
            addr_d    = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            pass_d    = 1'b0;
            cnt_d     = 16'd0;
          end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (state_q == RD_ID) begin
          id_d    = av_readdata;
          addr_d  = 1'b1;
          cnt_d   = 16'd0;
          state_d = RD_TS;
        end else begin
          // The ID term uses the word captured by the previous read.
          ts_d    = av_readdata;
          read_d  = 1'b0;
          addr_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (id_q == EXPECTED_ID) && ts_ok;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= 1'b0;
      read_q    <= 1'b0;
      id_q      <= 32'd0;
      ts_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= 16'd0;
      req_q     <= 1'b0;
      arm_q     <= AUTO_START;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      arm_q     <= arm_d;
    end
  end

  assign av_address = addr_q;
  assign av_read    = read_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: two instances (timestamp checked with
// auto-start and a 4-cycle timeout; timestamp ignored, manual start).
module tb_sysid_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] id_word = 32'h5A5A_1234;
  logic [31:0] ts_word = 32'h4741_C3C3;

  logic        addr1, read1, busy1, done1, pass1, to1;
  logic        addr2, read2, busy2, done2, pass2, to2;
  logic [31:0] rdata1, rdata2, id1, ts1, id2, ts2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata1 = addr1 ? ts_word : id_word;
  assign rdata2 = addr2 ? ts_word : id_word;

  sysid_checker #(
    .EXPECTED_ID(32'h5A5A_1234), .EXPECTED_TS(32'h4741_C3C3),
    .CHECK_TS(1'b1), .AUTO_START(1'b1), .TIMEOUT_CYCLES(4)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .av_address(addr1), .av_read(read1), .av_waitrequest(wr), .av_readdata(rdata1),
    .id_q(id1), .ts_q(ts1), .busy(busy1), .done(done1), .pass(pass1), .timeout(to1)
  );

  sysid_checker #(
    .EXPECTED_ID(32'h5A5A_1234), .EXPECTED_TS(32'h4741_C3C3),
    .CHECK_TS(1'b0), .AUTO_START(1'b0), .TIMEOUT_CYCLES(255)
  ) u_dut_nots (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .av_address(addr2), .av_read(read2), .av_waitrequest(wr), .av_readdata(rdata2),
    .id_q(id2), .ts_q(ts2), .busy(busy2), .done(done2), .pass(pass2), .timeout(to2)
  );

  // Status word {busy, done, pass, timeout, av_read, av_address}
  function automatic logic [31:0] st(input int sel);
    if (sel == 0) return {26'd0, busy1, done1, pass1, to1, read1, addr1};
    return {26'd0, busy2, done2, pass2, to2, read2, addr2};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, then run until done (bounded); reports the
  // start-to-done latency, the number of read cycles and the address sequence.
  task automatic run(input int sel, output int cyc, output int rds, output logic [1:0] addrs);
    logic d;
    rds = 0;
    addrs = 2'b00;
    if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
    tick();
    cyc = 1;
    check_eq("launch_status", st(sel), 32'b100010);
    while (1) begin
      if ((sel == 0 ? read1 : read2) == 1'b1) begin
        rds++;
        addrs = {addrs[0], (sel == 0 ? addr1 : addr2)};
      end
      d = (sel == 0) ? done1 : done2;
      if (d || cyc >= 40) break;
      tick();
      cyc++;
    end
    $display("run inst %0d latency %0d reads %0d status %b", sel, cyc, rds, st(sel));
  endtask

  int          cyc, rds;
  logic [1:0]  addrs;
  logic [7:1]  wr_tbl;

  initial begin
    // Reset state
    #2;
    check_eq("rst_status", st(0), 32'd0);
    check_eq("rst_id", id1, 32'd0);
    check_eq("rst_ts", ts1, 32'd0);
    tick();
    reset_n = 1'b1;

    // Auto-start: release edge is E0, read rises at E1, done at E3
    tick();
    check_eq("auto_e0", st(0), 32'b000000);
    tick();
    check_eq("auto_e1", st(0), 32'b100010);
    tick();
    check_eq("auto_e2", st(0), 32'b100011);
    check_eq("auto_e2_id", id1, 32'h5A5A_1234);
    tick();
    check_eq("auto_e3", st(0), 32'b011000);
    check_eq("auto_ts", ts1, 32'h4741_C3C3);
    $display("auto-start check complete");

    // Zero-wait match
    run(0, cyc, rds, addrs);
    check_eq("zw_latency", cyc, 3);
    check_eq("zw_reads", rds, 2);
    check_eq("zw_addrs", {30'd0, addrs}, 32'b01);
    check_eq("zw_status", st(0), 32'b011000);
    check_eq("zw_id", id1, 32'h5A5A_1234);
    check_eq("zw_ts", ts1, 32'h4741_C3C3);

    // ID mismatch
    id_word = 32'h5A5A_1235;
    run(0, cyc, rds, addrs);
    check_eq("idmm_status", st(0), 32'b010000);
    check_eq("idmm_id", id1, 32'h5A5A_1235);

    // Wrong timestamp: fails when checked, passes when ignored
    id_word = 32'h5A5A_1234;
    ts_word = 32'hDEAD_BEEF;
    run(0, cyc, rds, addrs);
    check_eq("tsmm_status", st(0), 32'b010000);
    run(1, cyc, rds, addrs);
    check_eq("nots_latency", cyc, 3);
    check_eq("nots_status", st(1), 32'b011000);
    check_eq("nots_ts", ts2, 32'hDEAD_BEEF);
    ts_word = 32'h4741_C3C3;

    // Wait states: 3 on the ID read, 2 on the timestamp read
    wr_tbl = 7'b0110111;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        check_eq($sformatf("ws_hold_%0d", k), st(0), {26'd0, 5'b10001, (k >= 5)});
        wr = wr_tbl[k];
      end
    end
    check_eq("ws_done", st(0), 32'b011000);
    check_eq("ws_ts", ts1, 32'h4741_C3C3);
    wr = 1'b0;
    $display("wait-state check complete");

    // Start while busy is ignored; start in DONE restarts
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    start1 = 1'b1;
    tick();
    tick();
    start1 = 1'b0;
    check_eq("ign_done", st(0), 32'b011000);
    tick();
    tick();
    check_eq("ign_no_restart", st(0), 32'b011000);
    id_word = 32'h1111_2222;
    run(0, cyc, rds, addrs);
    check_eq("restart_latency", cyc, 3);
    check_eq("restart_status", st(0), 32'b010000);
    check_eq("restart_id", id1, 32'h1111_2222);
    id_word = 32'h5A5A_1234;
    $display("restart/ignore check complete");

    // Reset asserted in RD_TS
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    check_eq("mid_in_rdts", st(0), 32'b100011);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_async_status", st(0), 32'd0);
    check_eq("mid_async_id", id1, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("mid_rel_e0", st(0), 32'b000000);
    tick();
    check_eq("mid_rel_e1", st(0), 32'b100010);
    tick();
    tick();
    check_eq("mid_rel_done", st(0), 32'b011000);
    $display("mid-read reset check complete");

    // Timeout: waitrequest stuck high across the auto-started check
    reset_n = 1'b0;
    wr = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check_eq("to_e1", st(0), 32'b100010);
    tick();
    tick();
    tick();
    check_eq("to_e4_pending", st(0), 32'b100010);
    tick();
    check_eq("to_e5", st(0), 32'b010100);
    check_eq("to_id", id1, 32'd0);
    wr = 1'b0;
    $display("timeout check complete");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
